lc3_sram_responder: RTL
=======================

// Module: lc3_sram_responder
// PURPOSE
//  Memory-side responder for the LC-3 control unit's active-low SRAM strobes
//  (Mem_CE/UB/LB/OE/WE). Backs the CPU's MAR/MDR bus with an on-chip word array.
//  Reads have programmable latency; writes take byte lanes; both are counted.
//  Protocol misuse raises sticky error flags. Used in simulation and on FPGA in
//  place of the external SRAM.
// PARAMETERS
//  DEPTH     1024  number of 16-bit words; valid addresses 0..DEPTH-1
//  READ_LAT  1     cycles from first OE-low cycle to Rd_valid (1..7)
// PORTS
//  Clk            in   1   system clock, rising edge
//  Reset          in   1   synchronous, active-high
//  Mem_CE         in   1   chip enable, active low; high = all strobes ignored
//  Mem_UB         in   1   upper byte lane enable, active low (writes only)
//  Mem_LB         in   1   lower byte lane enable, active low (writes only)
//  Mem_OE         in   1   output enable / read request, active low
//  Mem_WE         in   1   write enable, active low
//  ADDR           in   20  word address
//  Data_from_CPU  in   16  write data (MDR)
//  Data_to_CPU    out  16  read data
//  Rd_valid       out  1   Data_to_CPU holds mem[latched addr]
//  Wr_done        out  1   one-cycle pulse: write committed
//  Conflict_err   out  1   sticky: OE and WE low together under CE low
//  Range_err      out  1   sticky: access with ADDR >= DEPTH
//  Access_count   out  16  completed reads + committed writes, wraps FFFF->0000
// BEHAVIOUR
//  Reset: state IDLE; Data_to_CPU=0, Rd_valid=0, Wr_done=0, errors=0,
//   Access_count=0. Array contents preserved. Reset mid-access aborts it:
//   no commit, no count.
//  States: IDLE, RD_WAIT, RD_HOLD, WR_HOLD. Request = Mem_CE low, sampled each edge.
//  IDLE: if OE low and WE high -> latch ADDR, load latency counter with
//   READ_LAT-1 and go to RD_WAIT. If WE low -> go to WR_HOLD.
//  WR_HOLD entry: on the IDLE edge, write ADDR with the byte lanes enabled by
//   UB/LB. UB=LB=1 writes nothing but still counts. Wr_done=1 for the next cycle.
//  RD_WAIT: decrement the counter; at 0, on that edge:
//   Data_to_CPU <= mem[addr], Rd_valid <= 1, Access_count++, go to RD_HOLD.
//   With READ_LAT=1, OE low in cycle t gives Rd_valid=1 in cycle t+1. This
//   matches the two-cycle OE-low fetch in which MDR loads on the second cycle.
//  RD_HOLD: Rd_valid and data held while OE low, CE low and ADDR unchanged.
//   ADDR change -> relatch and go to RD_WAIT; Rd_valid=0 until data ready.
//   OE high or CE high -> IDLE, Rd_valid=0 next cycle; Data_to_CPU keeps value.
//  WR_HOLD: exactly one commit per WE-low assertion. Stays while WE low and CE
//   low, even if ADDR/data change. WE high or CE high -> IDLE.
//  OE released in RD_WAIT -> IDLE, no data update, no count.
//  OE and WE both low in IDLE: write wins, Conflict_err set. Same rule if WE
//   drops during RD_WAIT/RD_HOLD: abort read, Rd_valid=0, commit write, go to WR_HOLD.
//  ADDR >= DEPTH: read returns 16'h0000 (still Rd_valid, still counted);
//   write discarded (still Wr_done, counted); Range_err set.
//  Read-after-write to the same address returns the new data, byte-merged.
//  Mem_UB/LB ignored for reads: the full word is always returned.
// TESTING
//  1 Reset, write 16'hBEEF to addr 5 (UB=LB=0, WE low 1 cycle) -> Wr_done pulse
//    next cycle, Access_count=1; read addr 5 -> Rd_valid cycle t+1, data BEEF.
//  2 LB-only write 16'h1234 to addr 5 -> read returns BE34; UB-only 16'hAA00
//    -> AA34.
//  3 READ_LAT=3: OE low at t -> Rd_valid low t+1..t+2, high t+3; OE released at
//    t+2 -> no Rd_valid, count unchanged.
//  4 OE and WE low together, addr 7, data 0x0F0F -> mem[7]=0F0F, Conflict_err=1
//    and stays 1 until Reset.
//  5 Read ADDR=DEPTH -> Data_to_CPU=0000, Range_err=1; write there -> mem[0] intact.
//  6 Hold WE low 5 cycles with ADDR stepping -> one commit only; Reset during
//    RD_WAIT -> Rd_valid=0, Access_count=0, IDLE; 65536 accesses wrap count to 0.

Source files
------------

// File: rtl/lc3_sram_responder_if.sv
// Bus between the LC-3 control unit and its SRAM.
// Carries the active-low strobes, the address and write data from the CPU.
// Carries the read data, status pulses, sticky error flags and the access
// counter back from the memory side.
interface lc3_sram_responder_if;
    logic        memCe;
    logic        memUb;
    logic        memLb;
    logic        memOe;
    logic        memWe;
    logic [19:0] addr;
    logic [15:0] dataFromCpu;
    logic [15:0] dataToCpu;
    logic        rdValid;
    logic        wrDone;
    logic        conflictErr;
    logic        rangeErr;
    logic [15:0] accessCount;

    modport master (
        output memCe, memUb, memLb, memOe, memWe, addr, dataFromCpu,
        input  dataToCpu, rdValid, wrDone, conflictErr, rangeErr, accessCount
    );

    modport slave (
        input  memCe, memUb, memLb, memOe, memWe, addr, dataFromCpu,
        output dataToCpu, rdValid, wrDone, conflictErr, rangeErr, accessCount
    );
endinterface

// File: rtl/lc3_sram_responder.sv
// On-chip stand-in for the LC-3 external SRAM.
// Answers the control unit's active-low strobes from a 16-bit word array.
// Reads take READ_LAT edges of OE low before data is valid. Writes commit
// once per WE-low assertion with byte-lane masking. Completed reads and
// committed writes are counted. Strobe misuse and out-of-range addresses
// raise sticky error flags.
module lc3_sram_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    lc3_sram_responder_if.slave sramBus
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  latCnt_q, latCnt_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rdValid_q, rdValid_d;
    logic        wrDone_q;
    logic        conflict_q, conflict_d;
    logic        range_q, range_d;
    logic [15:0] count_q, count_d;

    logic [15:0] mem [DEPTH];

    logic          req;
    logic          rdReq;
    logic          wrReq;
    logic          wrCommit;
    logic          rdDone;
    logic [19:0]   rdAddr;
    logic          rdInRange;
    logic          wrInRange;
    logic [AW-1:0] rdIdx;
    logic [AW-1:0] wrIdx;
    logic [15:0]   rdWord;

    assign req   = ~sramBus.memCe;
    assign wrReq = req & ~sramBus.memWe;
    assign rdReq = req & ~sramBus.memOe & sramBus.memWe;

    // A read finishing out of RD_WAIT uses the latched address; one that
    // finishes on its first edge (READ_LAT=1) uses the live bus address.
    always_comb begin
        rdAddr = sramBus.addr;
        if (state_q == RD_WAIT) begin
            rdAddr = addr_q;
        end
    end

    assign rdInRange = ({12'd0, rdAddr} < 32'(DEPTH));
    assign wrInRange = ({12'd0, sramBus.addr} < 32'(DEPTH));
    assign rdIdx     = rdAddr[AW-1:0];
    assign wrIdx     = sramBus.addr[AW-1:0];
    assign rdWord    = rdInRange ? mem[rdIdx] : 16'h0000;

    // Next-state logic: a write request always wins over a read, an address
    // change during a held read restarts the fetch, and releasing the strobes
    // returns to IDLE without touching the data register.
    always_comb begin
        state_d    = state_q;
        latCnt_d   = latCnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdValid_d  = rdValid_q;
        conflict_d = conflict_q;
        range_d    = range_q;
        count_d    = count_q;
        wrCommit   = 1'b0;
        rdDone     = 1'b0;

        if (req && !sramBus.memOe && !sramBus.memWe) begin
            conflict_d = 1'b1;
        end

        case (state_q)
            IDLE, RD_HOLD: begin
                if (wrReq) begin
                    wrCommit  = 1'b1;
                    rdValid_d = 1'b0;
                    state_d   = WR_HOLD;
                end else if (rdReq) begin
                    if (state_q == IDLE || sramBus.addr != addr_q) begin
                        addr_d    = sramBus.addr;
                        rdValid_d = 1'b0;
                        if (LAT_INIT == 3'd0) begin
                            rdDone = 1'b1;
                        end else begin
                            latCnt_d = LAT_INIT;
                            state_d  = RD_WAIT;
                        end
                    end
                end else begin
                    rdValid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_WAIT: begin
                if (wrReq) begin
                    wrCommit  = 1'b1;
                    rdValid_d = 1'b0;
                    state_d   = WR_HOLD;
                end else if (rdReq) begin
                    latCnt_d = latCnt_q - 3'd1;
                    if (latCnt_q == 3'd1) begin
                        rdDone = 1'b1;
                    end
                end else begin
                    rdValid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WR_HOLD: begin
                if (!wrReq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rdDone) begin
            data_d    = rdWord;
            rdValid_d = 1'b1;
            count_d   = count_q + 16'd1;
            state_d   = RD_HOLD;
            if (!rdInRange) begin
                range_d = 1'b1;
            end
        end

        if (wrCommit) begin
            count_d = count_q + 16'd1;
            if (!wrInRange) begin
                range_d = 1'b1;
            end
        end
    end

    // Control and status registers; reset aborts any access in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            latCnt_q   <= 3'd0;
            addr_q     <= 20'd0;
            data_q     <= 16'h0000;
            rdValid_q  <= 1'b0;
            wrDone_q   <= 1'b0;
            conflict_q <= 1'b0;
            range_q    <= 1'b0;
            count_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            latCnt_q   <= latCnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdValid_q  <= rdValid_d;
            wrDone_q   <= wrCommit;
            conflict_q <= conflict_d;
            range_q    <= range_d;
            count_q    <= count_d;
        end
    end

    // Word array with per-lane write enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wrCommit && wrInRange) begin
            if (!sramBus.memLb) begin
                mem[wrIdx][7:0] <= sramBus.dataFromCpu[7:0];
            end
            if (!sramBus.memUb) begin
                mem[wrIdx][15:8] <= sramBus.dataFromCpu[15:8];
            end
        end
    end

    assign sramBus.dataToCpu   = data_q;
    assign sramBus.rdValid     = rdValid_q;
    assign sramBus.wrDone      = wrDone_q;
    assign sramBus.conflictErr = conflict_q;
    assign sramBus.rangeErr    = range_q;
    assign sramBus.accessCount = count_q;

endmodule
